// File: rtl/music_pkg.sv
// Shared definitions for the music playlist controller: FSM state
// encoding, default parameters, song index width and index helpers.
package music_pkg;

    localparam int CLK_FRE_DEF   = 50_000_000;
    localparam int NUM_SONGS_DEF = 3;
    localparam int IDX_W         = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_PLAYING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    function automatic logic [IDX_W-1:0] idx_inc(
        input logic [IDX_W-1:0] i,
        input int               n
    );
        if (int'(i) == n - 1) return '0;
        return i + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] idx_dec(
        input logic [IDX_W-1:0] i,
        input int               n
    );
        if (i == '0) return IDX_W'(n - 1);
        return i - 1'b1;
    endfunction

endpackage

// File: rtl/music_gap_timer.sv
// Down-counter that times the silence between songs.
// Ports: clk, rst_n, load_i (load GAP_CYCLES-1), en_i (count down), zero_o.
module music_gap_timer #(
    parameter int GAP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    localparam int W = $clog2(GAP_CYCLES + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(GAP_CYCLES - 1);
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/music_playlist_ctrl.sv
// Playlist sequencer for NUM_SONGS external song players.
// Ports: buttons/repeat_all/play_done/buzzer_in in; play_en, run, buzzer, song_idx, busy out.
module music_playlist_ctrl
    import music_pkg::*;
#(
    parameter int CLK_FRE    = CLK_FRE_DEF,
    parameter int NUM_SONGS  = NUM_SONGS_DEF,
    parameter int GAP_CYCLES = CLK_FRE / 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_play,
    input  logic                 btn_next,
    input  logic                 btn_prev,
    input  logic                 repeat_all,
    input  logic [NUM_SONGS-1:0] play_done,
    input  logic [NUM_SONGS-1:0] buzzer_in,
    output logic [NUM_SONGS-1:0] play_en,
    output logic                 run,
    output logic                 buzzer,
    output logic [IDX_W-1:0]     song_idx,
    output logic                 busy
);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_SONGS-1:0] play_en_q;
    logic                 run_q;
    logic                 buzzer_q;
    logic                 gap_load;
    logic                 gap_zero;
    logic                 done_sel;

    // Only the selected player's end-of-song pulse matters.
    assign done_sel = play_done[idx_q];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_play) begin
                    state_d = ST_START;
                end else if (btn_next && !btn_prev) begin
                    idx_d = idx_inc(idx_q, NUM_SONGS);
                end else if (btn_prev && !btn_next) begin
                    idx_d = idx_dec(idx_q, NUM_SONGS);
                end
            end
            ST_START: begin
                state_d = ST_PLAYING;
            end
            ST_PLAYING, ST_PAUSED: begin
                // End of song outranks a simultaneous pause/resume press.
                if (done_sel) begin
                    state_d  = ST_GAP;
                    idx_d    = idx_inc(idx_q, NUM_SONGS);
                    gap_load = 1'b1;
                end else if (btn_play) begin
                    state_d = (state_q == ST_PLAYING) ? ST_PAUSED
                                                      : ST_PLAYING;
                end
            end
            ST_GAP: begin
                if (btn_play) begin
                    state_d = ST_IDLE;
                end else if (gap_zero) begin
                    state_d = (repeat_all || idx_q != '0) ? ST_START
                                                          : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    music_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(gap_load),
        .en_i  (state_q == ST_GAP),
        .zero_o(gap_zero)
    );

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            play_en_q <= '0;
            run_q     <= 1'b0;
            buzzer_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            play_en_q <= (state_d == ST_START)
                         ? (NUM_SONGS'(1) << idx_d) : '0;
            run_q     <= (state_d == ST_PLAYING);
            buzzer_q  <= (state_d == ST_PLAYING) ? buzzer_in[idx_q] : 1'b1;
        end
    end

    assign play_en  = play_en_q;
    assign run      = run_q;
    assign buzzer   = buzzer_q;
    assign song_idx = idx_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
